// File: rtl/pal_timing_detect.sv
// Native PAL timing detector: measures line period, lines per frame and the first
// active pixel/line, then publishes upscaler offsets once the timing is stable.
module pal_timing_detect #(
  parameter int unsigned BLACK_THRESH    = 8,
  parameter int unsigned HOFF_SHIFT      = 2,
  parameter int unsigned STABLE_FRAMES   = 4,
  parameter int unsigned PERIOD_TOL      = 2,
  parameter int unsigned MIN_LINES       = 200,
  parameter int unsigned MAX_LINE_PERIOD = 8191
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pal_hsync,
  input  logic        i_pal_vsync,
  input  logic [7:0]  i_pal_r,
  input  logic [7:0]  i_pal_g,
  input  logic [7:0]  i_pal_b,
  output logic [12:0] o_line_period,
  output logic [10:0] o_lines,
  output logic [7:0]  o_hoffset,
  output logic [7:0]  o_voffset,
  output logic        o_valid,
  output logic        o_changed
);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_e;

  localparam logic [7:0]  THRESH    = 8'(BLACK_THRESH);
  localparam logic [12:0] PIX_LIMIT = 13'(MAX_LINE_PERIOD);
  localparam logic [12:0] TOL       = 13'(PERIOD_TOL);
  localparam logic [10:0] LINE_MIN  = 11'(MIN_LINES);
  localparam logic [3:0]  LOCK_AT   = 4'(STABLE_FRAMES - 2);
  localparam logic [12:0] PIX_NONE  = 13'h1FFF;
  localparam logic [10:0] LINE_NONE = 11'h7FF;

  state_e      state_q, state_d;
  logic        hsPrev_q, vsPrev_q;
  logic [12:0] pixCnt_q, pixCnt_d, lastPeriod_q, lastPeriod_d;
  logic [12:0] frmMinPix_q, frmMinPix_d, candPeriod_q, candPeriod_d;
  logic [10:0] lineCnt_q, lineCnt_d, frmFirstLine_q, frmFirstLine_d;
  logic [10:0] candLines_q, candLines_d;
  logic [3:0]  stableCnt_q, stableCnt_d;
  logic [12:0] period_q, period_d;
  logic [10:0] lines_q, lines_d;
  logic [7:0]  hoff_q, hoff_d, voff_q, voff_d;
  logic        valid_q, valid_d, changed_q, changed_d;

  logic        lineStart, frameStart, pixActive, timeout, match, blackFrame;
  logic        loadAll, loadOffsets;
  logic [12:0] periodDiff, minShifted;
  logic [7:0]  hoffNew, voffNew;

  assign lineStart  = i_pal_hsync & ~hsPrev_q;
  assign frameStart = ~i_pal_vsync & vsPrev_q;
  assign pixActive  = (i_pal_r > THRESH) | (i_pal_g > THRESH) | (i_pal_b > THRESH);
  assign timeout    = (pixCnt_q >= PIX_LIMIT) | (lineCnt_q == LINE_NONE);
  assign periodDiff = (lastPeriod_q >= candPeriod_q) ? lastPeriod_q - candPeriod_q
                                                     : candPeriod_q - lastPeriod_q;
  assign match      = (lineCnt_q == candLines_q) && (periodDiff <= TOL) && (lineCnt_q >= LINE_MIN);
  assign blackFrame = (frmFirstLine_q == LINE_NONE);
  assign minShifted = frmMinPix_q >> HOFF_SHIFT;
  assign hoffNew    = (minShifted > 13'd255) ? 8'hFF : minShifted[7:0];
  assign voffNew    = (frmFirstLine_q > 11'd255) ? 8'hFF : frmFirstLine_q[7:0];

  // A frame start wins over a coincident line start: no line is counted or sampled.
  always_comb begin
    pixCnt_d       = pixCnt_q;
    lineCnt_d      = lineCnt_q;
    lastPeriod_d   = lastPeriod_q;
    frmMinPix_d    = frmMinPix_q;
    frmFirstLine_d = frmFirstLine_q;
    if (frameStart) begin
      pixCnt_d       = '0;
      lineCnt_d      = '0;
      frmMinPix_d    = PIX_NONE;
      frmFirstLine_d = LINE_NONE;
    end else begin
      if (lineStart) begin
        pixCnt_d     = '0;
        lineCnt_d    = (lineCnt_q == LINE_NONE) ? lineCnt_q : lineCnt_q + 11'd1;
        lastPeriod_d = pixCnt_q + 13'd1;
      end else if (pixCnt_q != PIX_NONE) begin
        pixCnt_d = pixCnt_q + 13'd1;
      end
      if (pixActive && !lineStart) begin
        if (pixCnt_q < frmMinPix_q) frmMinPix_d = pixCnt_q;
        if (frmFirstLine_q == LINE_NONE) frmFirstLine_d = lineCnt_q;
      end
    end
    if (timeout) begin
      pixCnt_d       = '0;
      lineCnt_d      = '0;
      lastPeriod_d   = '0;
      frmMinPix_d    = PIX_NONE;
      frmFirstLine_d = LINE_NONE;
    end
  end

  always_comb begin
    state_d      = state_q;
    stableCnt_d  = stableCnt_q;
    candLines_d  = candLines_q;
    candPeriod_d = candPeriod_q;
    valid_d      = valid_q;
    lines_d      = lines_q;
    period_d     = period_q;
    hoff_d       = hoff_q;
    voff_d       = voff_q;
    changed_d    = 1'b0;
    loadAll      = 1'b0;
    loadOffsets  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frameStart) begin
          state_d      = S_MEASURE;
          stableCnt_d  = '0;
          candLines_d  = '0;
          candPeriod_d = '0;
        end
      end
      S_MEASURE: begin
        if (frameStart) begin
          candLines_d  = lineCnt_q;
          candPeriod_d = lastPeriod_q;
          if (match) begin
            stableCnt_d = stableCnt_q + 4'd1;
            if (stableCnt_q == LOCK_AT) begin
              state_d = S_LOCKED;
              loadAll = 1'b1;
            end
          end else begin
            stableCnt_d = '0;
          end
        end
      end
      S_LOCKED: begin
        if (frameStart) begin
          candLines_d  = lineCnt_q;
          candPeriod_d = lastPeriod_q;
          if (match) begin
            loadOffsets = 1'b1;
          end else begin
            state_d     = S_MEASURE;
            stableCnt_d = '0;
            valid_d     = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d     = S_IDLE;
      stableCnt_d = '0;
      valid_d     = 1'b0;
      loadAll     = 1'b0;
      loadOffsets = 1'b0;
    end
    if (loadAll) begin
      lines_d  = lineCnt_q;
      period_d = lastPeriod_q;
      valid_d  = 1'b1;
    end
    // An all-black frame still counts for timing but keeps the previous offsets.
    if ((loadAll || loadOffsets) && !blackFrame) begin
      hoff_d = hoffNew;
      voff_d = voffNew;
    end
    changed_d = (loadAll || loadOffsets) &&
                ({lines_d, period_d, hoff_d, voff_d, valid_d} != {lines_q, period_q, hoff_q, voff_q, valid_q});
  end

  always_ff @(posedge clk) begin
    hsPrev_q <= i_pal_hsync;
    vsPrev_q <= i_pal_vsync;
    if (!reset) begin
      state_q        <= S_IDLE;
      pixCnt_q       <= '0;
      lineCnt_q      <= '0;
      lastPeriod_q   <= '0;
      frmMinPix_q    <= PIX_NONE;
      frmFirstLine_q <= LINE_NONE;
      candLines_q    <= '0;
      candPeriod_q   <= '0;
      stableCnt_q    <= '0;
      lines_q        <= '0;
      period_q       <= '0;
      hoff_q         <= '0;
      voff_q         <= '0;
      valid_q        <= 1'b0;
      changed_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pixCnt_q       <= pixCnt_d;
      lineCnt_q      <= lineCnt_d;
      lastPeriod_q   <= lastPeriod_d;
      frmMinPix_q    <= frmMinPix_d;
      frmFirstLine_q <= frmFirstLine_d;
      candLines_q    <= candLines_d;
      candPeriod_q   <= candPeriod_d;
      stableCnt_q    <= stableCnt_d;
      lines_q        <= lines_d;
      period_q       <= period_d;
      hoff_q         <= hoff_d;
      voff_q         <= voff_d;
      valid_q        <= valid_d;
      changed_q      <= changed_d;
    end
  end

  assign o_line_period = period_q;
  assign o_lines       = lines_q;
  assign o_hoffset     = hoff_q;
  assign o_voffset     = voff_q;
  assign o_valid       = valid_q;
  assign o_changed     = changed_q;

endmodule
